branch_predictor_bht: RTL and testbench

//  Dynamic branch predictor and next-PC select for the 5-stage pipeline; replaces static "always taken".

---
 rtl/branch_predictor_bht.sv | 135 +++++++++++++
 tb/tb_branch_predictor_bht.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor_bht.sv
// Dynamic branch predictor with next-PC select for the 5-stage pipeline.
// A direct-mapped table of 2-bit saturating counters is read in IF and
// trained in ID. The block also picks the next-PC source, flushes IF/ID on
// redirects, and keeps saturating counts of resolved and mispredicted branches.
module branch_predictor_bht #(
   parameter int IDX_W  = 4,
   parameter int STAT_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       if_pc,
   input  logic              if_is_branch,
   input  logic              id_is_branch,
   input  logic [31:0]       id_pc,
   input  logic              id_taken,
   input  logic              id_pred_taken,
   input  logic [1:0]        Jump,
   output logic              pred_taken,
   output logic [1:0]        Branch,
   output logic              IF_flush,
   output logic [STAT_W-1:0] branch_cnt,
   output logic [STAT_W-1:0] mispred_cnt
);

   localparam int DEPTH = 1 << IDX_W;
   localparam logic [STAT_W-1:0] STAT_ONE = 1;
   localparam logic [STAT_W-1:0] STAT_MAX = '1;

   // Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
   // Reset value is weak-T so a cold table behaves like the old static policy.
   typedef enum logic [1:0] {
      STRONG_NT = 2'b00,
      WEAK_NT   = 2'b01,
      WEAK_T    = 2'b10,
      STRONG_T  = 2'b11
   } counterState_t;

   logic [1:0]        tbl_q [DEPTH];
   logic [1:0]        trainCnt_d;
   logic [STAT_W-1:0] branchCnt_q, branchCnt_d;
   logic [STAT_W-1:0] mispredCnt_q, mispredCnt_d;

   logic [IDX_W-1:0]  ifIdx;
   logic [IDX_W-1:0]  idIdx;
   logic              mispredict;
   logic              unusedPcBits;

   assign ifIdx        = if_pc[IDX_W+1:2];
   assign idIdx        = id_pc[IDX_W+1:2];
   assign unusedPcBits = ^{if_pc[31:IDX_W+2], if_pc[1:0], id_pc[31:IDX_W+2], id_pc[1:0]};

   assign mispredict   = id_is_branch & (id_taken ^ id_pred_taken);
   assign branch_cnt   = branchCnt_q;
   assign mispred_cnt  = mispredCnt_q;

   // Lookup reads the registered table directly, so a same-cycle train on the
   // same index is not visible until the following cycle.
   always_comb begin
      pred_taken = 1'b0;
      if (if_is_branch) begin
         pred_taken = tbl_q[ifIdx][1];
      end
   end

   // Next value for the counter being trained: move toward the outcome and
   // hold at the strong ends.
   always_comb begin
      trainCnt_d = tbl_q[idIdx];
      if (id_taken) begin
         if (tbl_q[idIdx] != STRONG_T) begin
            trainCnt_d = tbl_q[idIdx] + 2'b01;
         end
      end else begin
         if (tbl_q[idIdx] != STRONG_NT) begin
            trainCnt_d = tbl_q[idIdx] - 2'b01;
         end
      end
   end

   // Next-PC select and flush: an ID-stage correction outranks an IF-stage
   // taken prediction; a jump in ID always flushes but leaves the select alone.
   always_comb begin
      Branch   = 2'b00;
      IF_flush = 1'b0;
      if (mispredict && id_taken) begin
         Branch   = 2'b11;
         IF_flush = 1'b1;
      end else if (mispredict && !id_taken) begin
         Branch   = 2'b10;
         IF_flush = 1'b1;
      end else if (if_is_branch && pred_taken) begin
         Branch   = 2'b01;
         IF_flush = 1'b0;
      end
      if (Jump == 2'b01 || Jump == 2'b10) begin
         IF_flush = 1'b1;
      end
   end

   // Statistics next-state: both counters stick at all-ones instead of
   // wrapping, and the mispredict count only moves together with a branch.
   always_comb begin
      branchCnt_d  = branchCnt_q;
      mispredCnt_d = mispredCnt_q;
      if (id_is_branch && branchCnt_q != STAT_MAX) begin
         branchCnt_d = branchCnt_q + STAT_ONE;
      end
      if (mispredict && mispredCnt_q != STAT_MAX) begin
         mispredCnt_d = mispredCnt_q + STAT_ONE;
      end
   end

   // Table storage with a single write port driven from ID.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            tbl_q[i] <= WEAK_T;
         end
      end else if (id_is_branch) begin
         tbl_q[idIdx] <= trainCnt_d;
      end
   end

   // Statistics registers, cleared immediately by reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         branchCnt_q  <= '0;
         mispredCnt_q <= '0;
      end else begin
         branchCnt_q  <= branchCnt_d;
         mispredCnt_q <= mispredCnt_d;
      end
   end

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Directed testbench for branch_predictor_bht. A default instance checks
// prediction, select/flush and training; a second instance with 4-bit
// statistics, fed the same inputs, checks counter saturation.
module tb_branch_predictor_bht;

   logic        clk;
   logic        rst;
   logic [31:0] if_pc;
   logic        if_is_branch;
   logic        id_is_branch;
   logic [31:0] id_pc;
   logic        id_taken;
   logic        id_pred_taken;
   logic [1:0]  Jump;

   logic        pred_taken;
   logic [1:0]  Branch;
   logic        IF_flush;
   logic [15:0] branch_cnt;
   logic [15:0] mispred_cnt;

   logic        predTaken4;
   logic [1:0]  branch4;
   logic        ifFlush4;
   logic [3:0]  branchCnt4;
   logic [3:0]  mispredCnt4;

   int nChecks = 0;
   int nFail   = 0;

   branch_predictor_bht #(.IDX_W(4), .STAT_W(16)) dut (
      .clk(clk), .rst(rst), .if_pc(if_pc), .if_is_branch(if_is_branch),
      .id_is_branch(id_is_branch), .id_pc(id_pc), .id_taken(id_taken),
      .id_pred_taken(id_pred_taken), .Jump(Jump), .pred_taken(pred_taken),
      .Branch(Branch), .IF_flush(IF_flush), .branch_cnt(branch_cnt),
      .mispred_cnt(mispred_cnt)
   );

   branch_predictor_bht #(.IDX_W(4), .STAT_W(4)) dut4 (
      .clk(clk), .rst(rst), .if_pc(if_pc), .if_is_branch(if_is_branch),
      .id_is_branch(id_is_branch), .id_pc(id_pc), .id_taken(id_taken),
      .id_pred_taken(id_pred_taken), .Jump(Jump), .pred_taken(predTaken4),
      .Branch(branch4), .IF_flush(ifFlush4), .branch_cnt(branchCnt4),
      .mispred_cnt(mispredCnt4)
   );

   // Free-running clock, 10 ns period
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive every DUT input, then let combinational outputs settle
   task automatic applyStimulus(input logic ifBr, input logic [31:0] ifPc,
                                input logic idBr, input logic [31:0] idPc,
                                input logic idTk, input logic idPred,
                                input logic [1:0] jmp);
      if_is_branch  = ifBr;
      if_pc         = ifPc;
      id_is_branch  = idBr;
      id_pc         = idPc;
      id_taken      = idTk;
      id_pred_taken = idPred;
      Jump          = jmp;
      #2;
   endtask

   // Advance to just after the next rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Pulse reset between edges and come back aligned just after an edge
   task automatic doReset();
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 2'b00);
      @(negedge clk);
      rst = 1'b1;
      #2;
      rst = 1'b0;
      step();
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1;
      applyStimulus(1'b1, 32'h0000_0010, 1'b0, 32'h0, 1'b0, 1'b0, 2'b00);
      nChecks++; if (pred_taken !== 1'b1) begin nFail++; $display("[TB] FAIL reset_pred got %b want 1", pred_taken); end
      nChecks++; if (Branch !== 2'b01) begin nFail++; $display("[TB] FAIL reset_branch got %b want 01", Branch); end
      nChecks++; if (IF_flush !== 1'b0) begin nFail++; $display("[TB] FAIL reset_flush got %b want 0", IF_flush); end
      nChecks++; if (branch_cnt !== 16'd0 || mispred_cnt !== 16'd0) begin nFail++; $display("[TB] FAIL reset_counts got %0d/%0d want 0/0", branch_cnt, mispred_cnt); end
      applyStimulus(1'b1, 32'h0000_003C, 1'b0, 32'h0, 1'b0, 1'b0, 2'b00);
      nChecks++; if (pred_taken !== 1'b1) begin nFail++; $display("[TB] FAIL reset_pred_3c got %b want 1", pred_taken); end
      applyStimulus(1'b0, 32'h0000_003C, 1'b0, 32'h0, 1'b0, 1'b0, 2'b00);
      nChecks++; if (pred_taken !== 1'b0 || Branch !== 2'b00) begin nFail++; $display("[TB] FAIL reset_nobranch got %b/%b want 0/00", pred_taken, Branch); end
      rst = 1'b0;
      step();
   endtask

   task automatic test_train_not_taken();
      doReset();
      applyStimulus(1'b0, 32'h0, 1'b1, 32'h0000_0010, 1'b0, 1'b1, 2'b00);
      nChecks++; if (Branch !== 2'b10 || IF_flush !== 1'b1) begin nFail++; $display("[TB] FAIL nt1_select got %b/%b want 10/1", Branch, IF_flush); end
      step();
      nChecks++; if (branch_cnt !== 16'd1 || mispred_cnt !== 16'd1) begin nFail++; $display("[TB] FAIL nt1_counts got %0d/%0d want 1/1", branch_cnt, mispred_cnt); end
      applyStimulus(1'b0, 32'h0, 1'b1, 32'h0000_0010, 1'b0, 1'b0, 2'b00);
      nChecks++; if (Branch !== 2'b00 || IF_flush !== 1'b0) begin nFail++; $display("[TB] FAIL nt2_select got %b/%b want 00/0", Branch, IF_flush); end
      step();
      applyStimulus(1'b1, 32'h0000_0010, 1'b0, 32'h0, 1'b0, 1'b0, 2'b00);
      nChecks++; if (pred_taken !== 1'b0 || Branch !== 2'b00) begin nFail++; $display("[TB] FAIL nt_lookup got %b/%b want 0/00", pred_taken, Branch); end
      nChecks++; if (branch_cnt !== 16'd2 || mispred_cnt !== 16'd1) begin nFail++; $display("[TB] FAIL nt2_counts got %0d/%0d want 2/1", branch_cnt, mispred_cnt); end
      step();
   endtask

   task automatic test_saturate();
      doReset();
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1'b0, 32'h0, 1'b1, 32'h0000_0010, 1'b1, 1'b1, 2'b00);
         nChecks++; if (Branch !== 2'b00 || IF_flush !== 1'b0) begin nFail++; $display("[TB] FAIL sat_taken%0d got %b/%b want 00/0", k, Branch, IF_flush); end
         step();
      end
      applyStimulus(1'b0, 32'h0, 1'b1, 32'h0000_0010, 1'b0, 1'b1, 2'b00);
      nChecks++; if (Branch !== 2'b10 || IF_flush !== 1'b1) begin nFail++; $display("[TB] FAIL sat_nt_select got %b/%b want 10/1", Branch, IF_flush); end
      step();
      applyStimulus(1'b1, 32'h0000_0010, 1'b0, 32'h0, 1'b0, 1'b0, 2'b00);
      nChecks++; if (pred_taken !== 1'b1 || Branch !== 2'b01) begin nFail++; $display("[TB] FAIL sat_lookup got %b/%b want 1/01", pred_taken, Branch); end
      nChecks++; if (branch_cnt !== 16'd4 || mispred_cnt !== 16'd1) begin nFail++; $display("[TB] FAIL sat_counts got %0d/%0d want 4/1", branch_cnt, mispred_cnt); end
      // A second not-taken drops to weak-NT
      applyStimulus(1'b0, 32'h0, 1'b1, 32'h0000_0010, 1'b0, 1'b1, 2'b00);
      step();
      applyStimulus(1'b1, 32'h0000_0010, 1'b0, 32'h0, 1'b0, 1'b0, 2'b00);
      nChecks++; if (pred_taken !== 1'b0) begin nFail++; $display("[TB] FAIL sat_lookup2 got %b want 0", pred_taken); end
      step();
   endtask

   task automatic test_jump_priority();
      doReset();
      applyStimulus(1'b0, 32'h0, 1'b1, 32'h0000_0020, 1'b1, 1'b0, 2'b00);
      nChecks++; if (Branch !== 2'b11 || IF_flush !== 1'b1) begin nFail++; $display("[TB] FAIL mp_taken got %b/%b want 11/1", Branch, IF_flush); end
      applyStimulus(1'b0, 32'h0, 1'b1, 32'h0000_0020, 1'b1, 1'b0, 2'b01);
      nChecks++; if (Branch !== 2'b11 || IF_flush !== 1'b1) begin nFail++; $display("[TB] FAIL mp_jump got %b/%b want 11/1", Branch, IF_flush); end
      applyStimulus(1'b1, 32'h0000_0010, 1'b1, 32'h0000_0020, 1'b1, 1'b0, 2'b00);
      nChecks++; if (Branch !== 2'b11 || IF_flush !== 1'b1) begin nFail++; $display("[TB] FAIL mp_over_if got %b/%b want 11/1", Branch, IF_flush); end
      applyStimulus(1'b0, 32'h0, 1'b1, 32'h0000_0020, 1'b1, 1'b1, 2'b00);
      nChecks++; if (Branch !== 2'b00 || IF_flush !== 1'b0) begin nFail++; $display("[TB] FAIL correct_pred got %b/%b want 00/0", Branch, IF_flush); end
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 2'b10);
      nChecks++; if (Branch !== 2'b00 || IF_flush !== 1'b1) begin nFail++; $display("[TB] FAIL jump10 got %b/%b want 00/1", Branch, IF_flush); end
      applyStimulus(1'b1, 32'h0000_0010, 1'b0, 32'h0, 1'b0, 1'b0, 2'b10);
      nChecks++; if (Branch !== 2'b01 || IF_flush !== 1'b1) begin nFail++; $display("[TB] FAIL jump_ifpred got %b/%b want 01/1", Branch, IF_flush); end
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 2'b11);
      nChecks++; if (Branch !== 2'b00 || IF_flush !== 1'b0) begin nFail++; $display("[TB] FAIL jump11 got %b/%b want 00/0", Branch, IF_flush); end
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 2'b00);
   endtask

   task automatic test_same_cycle();
      doReset();
      // 0x10 and 0x50 both map to index 4
      applyStimulus(1'b1, 32'h0000_0010, 1'b1, 32'h0000_0050, 1'b0, 1'b1, 2'b00);
      nChecks++; if (pred_taken !== 1'b1) begin nFail++; $display("[TB] FAIL same_old_pred got %b want 1", pred_taken); end
      nChecks++; if (Branch !== 2'b10 || IF_flush !== 1'b1) begin nFail++; $display("[TB] FAIL same_select got %b/%b want 10/1", Branch, IF_flush); end
      step();
      applyStimulus(1'b1, 32'h0000_0010, 1'b0, 32'h0, 1'b0, 1'b0, 2'b00);
      nChecks++; if (pred_taken !== 1'b0 || Branch !== 2'b00) begin nFail++; $display("[TB] FAIL same_new_pred got %b/%b want 0/00", pred_taken, Branch); end
      applyStimulus(1'b1, 32'h0000_0014, 1'b0, 32'h0, 1'b0, 1'b0, 2'b00);
      nChecks++; if (pred_taken !== 1'b1) begin nFail++; $display("[TB] FAIL same_neighbour got %b want 1", pred_taken); end
      step();
   endtask

   task automatic test_stat_saturate();
      doReset();
      for (int k = 0; k < 20; k++) begin
         applyStimulus(1'b0, 32'h0, 1'b1, 32'h0000_0010, 1'b0, 1'b1, 2'b00);
         step();
         if (k == 14) begin
            nChecks++; if (branchCnt4 !== 4'hF || mispredCnt4 !== 4'hF) begin nFail++; $display("[TB] FAIL stat15 got %h/%h want F/F", branchCnt4, mispredCnt4); end
         end
      end
      applyStimulus(1'b1, 32'h0000_0010, 1'b0, 32'h0, 1'b0, 1'b0, 2'b00);
      nChecks++; if (branchCnt4 !== 4'hF || mispredCnt4 !== 4'hF) begin nFail++; $display("[TB] FAIL stat20 got %h/%h want F/F", branchCnt4, mispredCnt4); end
      nChecks++; if (branch_cnt !== 16'd20 || mispred_cnt !== 16'd20) begin nFail++; $display("[TB] FAIL stat20_wide got %0d/%0d want 20/20", branch_cnt, mispred_cnt); end
      nChecks++; if (pred_taken !== 1'b0) begin nFail++; $display("[TB] FAIL stat_trained got %b want 0", pred_taken); end
      // Reset mid-cycle: state must clear without waiting for an edge
      rst = 1'b1;
      #1;
      nChecks++; if (branchCnt4 !== 4'h0 || mispredCnt4 !== 4'h0 || branch_cnt !== 16'd0 || mispred_cnt !== 16'd0) begin nFail++; $display("[TB] FAIL async_counts got %h/%h/%0d/%0d want 0", branchCnt4, mispredCnt4, branch_cnt, mispred_cnt); end
      nChecks++; if (pred_taken !== 1'b1 || Branch !== 2'b01) begin nFail++; $display("[TB] FAIL async_table got %b/%b want 1/01", pred_taken, Branch); end
      @(negedge clk);
      rst = 1'b0;
      step();
      nChecks++; if (pred_taken !== 1'b1 || branch_cnt !== 16'd0) begin nFail++; $display("[TB] FAIL cold_start got %b/%0d want 1/0", pred_taken, branch_cnt); end
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 2'b00);
   endtask

   initial begin
      rst = 1'b0;
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 2'b00);
      $display("[TB] starting branch_predictor_bht tests");
      test_reset();
      test_train_not_taken();
      test_saturate();
      test_jump_priority();
      test_same_cycle();
      test_stat_saturate();
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

endmodule
